// File: rtl/cart_loader_if.sv
// Download/ROM-init bundle for cart_loader.
// Host side: DL_ACTIVE, DL_WR, DL_DATA (sequential bytes, implicit address).
// ROM side: INIT_ADDR, INIT_DATA, INIT_VALID, plus CFG_AW, LOADED, OVERFLOW.
// master = host/cartridge-slot view, slave = the loader itself.
interface cart_loader_if #(
  parameter int unsigned ADDR_W = 17
);
  logic              DL_ACTIVE;
  logic              DL_WR;
  logic [7:0]        DL_DATA;
  logic [ADDR_W-1:0] INIT_ADDR;
  logic [7:0]        INIT_DATA;
  logic              INIT_VALID;
  logic [4:0]        CFG_AW;
  logic              LOADED;
  logic              OVERFLOW;

  modport master (
    output DL_ACTIVE, DL_WR, DL_DATA,
    input  INIT_ADDR, INIT_DATA, INIT_VALID, CFG_AW, LOADED, OVERFLOW
  );

  modport slave (
    input  DL_ACTIVE, DL_WR, DL_DATA,
    output INIT_ADDR, INIT_DATA, INIT_VALID, CFG_AW, LOADED, OVERFLOW
  );
endinterface

// File: rtl/cart_loader.sv
// Cartridge ROM init-port writer: converts the host byte stream into
// INIT_ADDR/INIT_DATA/INIT_VALID writes, then sizes the image to a ROM
// address width (CFG_AW) and raises LOADED.
// Ports: CLK, nRST (async active-low), dl (cart_loader_if.slave).
module cart_loader #(
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned MIN_AW = 11,
  parameter int unsigned MAX_AW = 15
) (
  input logic          CLK,
  input logic          nRST,
  cart_loader_if.slave dl
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned AW_W  = 5;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_SIZE = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              act_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [AW_W-1:0]   aw_q, aw_d;
  logic [ADDR_W-1:0] init_addr_q, init_addr_d;
  logic [7:0]        init_data_q, init_data_d;
  logic              init_valid_q, init_valid_d;
  logic [AW_W-1:0]   cfg_aw_q, cfg_aw_d;
  logic              loaded_q, loaded_d;
  logic              overflow_q, overflow_d;

  logic rise_c, fall_c, fits_c;

  assign rise_c = dl.DL_ACTIVE & ~act_q;
  assign fall_c = ~dl.DL_ACTIVE & act_q;
  // Image fits in 2^aw bytes.
  assign fits_c = (64'(1) << aw_q) >= 64'(count_q);

  // State and output registers; act_q resets high so a download already in
  // progress at reset release is not mistaken for a new rising edge.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= S_IDLE;
      act_q        <= 1'b1;
      count_q      <= '0;
      aw_q         <= AW_W'(MIN_AW);
      init_addr_q  <= '0;
      init_data_q  <= '0;
      init_valid_q <= 1'b0;
      cfg_aw_q     <= AW_W'(MAX_AW);
      loaded_q     <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      act_q        <= dl.DL_ACTIVE;
      count_q      <= count_d;
      aw_q         <= aw_d;
      init_addr_q  <= init_addr_d;
      init_data_q  <= init_data_d;
      init_valid_q <= init_valid_d;
      cfg_aw_q     <= cfg_aw_d;
      loaded_q     <= loaded_d;
      overflow_q   <= overflow_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    aw_d         = aw_q;
    init_addr_d  = init_addr_q;
    init_data_d  = init_data_q;
    init_valid_d = 1'b0;
    cfg_aw_d     = cfg_aw_q;
    loaded_d     = loaded_q;
    overflow_d   = overflow_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (rise_c) begin
          state_d    = S_LOAD;
          count_d    = '0;
          overflow_d = 1'b0;
          loaded_d   = 1'b0;
        end
      end
      S_LOAD: begin
        if (fall_c) begin
          state_d = S_SIZE;
          aw_d    = AW_W'(MIN_AW);
        end else if (dl.DL_WR && dl.DL_ACTIVE) begin
          // Top counter bit set means the address space is exhausted.
          if (!count_q[ADDR_W]) begin
            init_valid_d = 1'b1;
            init_addr_d  = count_q[ADDR_W-1:0];
            init_data_d  = dl.DL_DATA;
            count_d      = count_q + CNT_W'(1);
          end else begin
            overflow_d = 1'b1;
          end
        end
      end
      S_SIZE: begin
        if (rise_c) begin
          state_d    = S_LOAD;
          count_d    = '0;
          overflow_d = 1'b0;
          loaded_d   = 1'b0;
        end else if (count_q == '0) begin
          state_d  = S_IDLE;
          loaded_d = 1'b0;
        end else if (fits_c || (aw_q == AW_W'(MAX_AW))) begin
          state_d  = S_DONE;
          cfg_aw_d = aw_q;
          loaded_d = 1'b1;
        end else begin
          aw_d = aw_q + AW_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign dl.INIT_ADDR  = init_addr_q;
  assign dl.INIT_DATA  = init_data_q;
  assign dl.INIT_VALID = init_valid_q;
  assign dl.CFG_AW     = cfg_aw_q;
  assign dl.LOADED     = loaded_q;
  assign dl.OVERFLOW   = overflow_q;

endmodule

// File: tb/tb_cart_loader.sv
// Bench for cart_loader: two instances (ADDR_W=17 and ADDR_W=10) share one
// download stream; each is compared every cycle against a transaction-level
// model, and directed literal checks pin the model.
module tb_cart_loader;

  localparam int unsigned MIN_AW = 11;
  localparam int unsigned MAX_AW = 15;

  logic       CLK = 1'b0;
  logic       nRST;
  logic       act, wr;
  logic [7:0] data;

  int checks = 0;
  int errors = 0;

  logic [7:0] lst [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};

  always #5 CLK = ~CLK;

  // Smallest reported width whose 2^aw covers n bytes, clamped to MAX_AW.
  function automatic int exp_aw(int n);
    int a;
    a = MIN_AW;
    while (a < MAX_AW && (1 << a) < n) a++;
    return a;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_i
    localparam int unsigned AW = (g == 0) ? 17 : 10;

    cart_loader_if #(.ADDR_W(AW)) bus ();
    assign bus.DL_ACTIVE = act;
    assign bus.DL_WR     = wr;
    assign bus.DL_DATA   = data;

    cart_loader #(.ADDR_W(AW), .MIN_AW(MIN_AW), .MAX_AW(MAX_AW)) dut (
      .CLK  (CLK),
      .nRST (nRST),
      .dl   (bus)
    );

    // Model state: download in progress, bytes stored, sizing delay left.
    bit m_actq, m_loading, m_loaded, m_ovf, m_rise, m_fall;
    int m_count, m_wait, m_cfg;
    bit e_valid;
    int e_addr, e_data;

    int wr_n = 0;
    int wr_last = -1;
    int data_at [16];

    always @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
        m_actq = 1'b1; m_loading = 1'b0; m_loaded = 1'b0; m_ovf = 1'b0;
        m_count = 0; m_wait = 0; m_cfg = MAX_AW;
        e_valid = 1'b0; e_addr = 0; e_data = 0;
      end else begin
        m_rise = act && !m_actq;
        m_fall = !act && m_actq;
        m_actq = act;
        e_valid = 1'b0;
        if (m_loading) begin
          if (m_fall) begin
            m_loading = 1'b0;
            m_wait = (m_count == 0) ? 1 : exp_aw(m_count) - MIN_AW + 1;
          end else if (wr && act) begin
            if (m_count < (1 << AW)) begin
              e_valid = 1'b1; e_addr = m_count; e_data = int'(data);
              m_count++;
            end else begin
              m_ovf = 1'b1;
            end
          end
        end else if (m_rise) begin
          m_loading = 1'b1; m_count = 0; m_ovf = 1'b0; m_loaded = 1'b0; m_wait = 0;
        end else if (m_wait > 0) begin
          m_wait--;
          if (m_wait == 0 && m_count != 0) begin
            m_loaded = 1'b1;
            m_cfg = exp_aw(m_count);
          end
        end
      end
    end

    // Per-cycle comparison plus a write log for the directed checks.
    always @(negedge CLK) begin
      if (nRST) begin
        checks++;
        if (bus.INIT_VALID !== e_valid || bus.INIT_ADDR !== AW'(e_addr) ||
            bus.INIT_DATA !== 8'(e_data) || bus.LOADED !== m_loaded ||
            bus.OVERFLOW !== m_ovf || bus.CFG_AW !== 5'(m_cfg)) begin
          errors++;
          $display("FAIL cycle_model[%0d] t=%0t got v=%0b a=%0h d=%0h ld=%0b ov=%0b aw=%0d exp v=%0b a=%0h d=%0h ld=%0b ov=%0b aw=%0d",
                   g, $time, bus.INIT_VALID, bus.INIT_ADDR, bus.INIT_DATA, bus.LOADED,
                   bus.OVERFLOW, bus.CFG_AW, e_valid, e_addr, e_data, m_loaded, m_ovf, m_cfg);
        end
        if (bus.INIT_VALID) begin
          wr_n++;
          wr_last = int'(bus.INIT_ADDR);
          if (int'(bus.INIT_ADDR) < 16) data_at[int'(bus.INIT_ADDR)] = int'(bus.INIT_DATA);
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(string name, int got, int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d (0x%0h) exp=%0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  // mode 0: random data, 1: data = addr[7:0], 2: fixed A1..D4 list.
  // gap 0 means a random 1..3 cycle spacing between strobes.
  task automatic download(int n, int gap, int mode);
    int sp;
    act = 1'b1; wr = 1'b0;
    tick();
    for (int i = 0; i < n; i++) begin
      wr = 1'b1;
      data = (mode == 1) ? 8'(i) : (mode == 2) ? lst[i % 4] : 8'($urandom);
      tick();
      wr = 1'b0;
      sp = (gap == 0) ? int'($urandom_range(1, 3)) : gap;
      for (int k = 1; k < sp; k++) tick();
    end
    act = 1'b0;
    wr = (mode == 0) ? 1'($urandom % 2) : 1'b0;
    tick();
    wr = 1'b0;
  endtask

  task automatic wait_loaded(string name, int lim);
    int k;
    k = 0;
    while (!g_i[0].bus.LOADED && k < lim) begin
      tick();
      k++;
    end
    chk(name, int'(g_i[0].bus.LOADED), 1);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int b0, b1, lo, n;
    act = 1'b0; wr = 1'b0; data = 8'h00; nRST = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_addr",   int'(g_i[0].bus.INIT_ADDR), 0);
    chk("rst_data",   int'(g_i[0].bus.INIT_DATA), 0);
    chk("rst_valid",  int'(g_i[0].bus.INIT_VALID), 0);
    chk("rst_cfg",    int'(g_i[0].bus.CFG_AW), 15);
    chk("rst_loaded", int'(g_i[0].bus.LOADED), 0);
    chk("rst_ovf",    int'(g_i[0].bus.OVERFLOW), 0);
    nRST = 1'b1;
    tick();

    // Four-byte image.
    b0 = g_i[0].wr_n;
    download(4, 1, 2);
    wait_loaded("loaded_4B", 6);
    chk("writes_4B", g_i[0].wr_n - b0, 4);
    chk("last_4B", g_i[0].wr_last, 3);
    chk("d0_4B", g_i[0].data_at[0], 'hA1);
    chk("d1_4B", g_i[0].data_at[1], 'hB2);
    chk("d2_4B", g_i[0].data_at[2], 'hC3);
    chk("d3_4B", g_i[0].data_at[3], 'hD4);
    chk("cfg_4B", int'(g_i[0].bus.CFG_AW), 11);

    // 8 KiB, strobe every third cycle.
    b0 = g_i[0].wr_n;
    b1 = g_i[1].wr_n;
    download(8192, 3, 1);
    wait_loaded("loaded_8K", 6);
    chk("writes_8K", g_i[0].wr_n - b0, 8192);
    chk("last_8K", g_i[0].wr_last, 'h1FFF);
    chk("cfg_8K", int'(g_i[0].bus.CFG_AW), 13);
    chk("small_writes_8K", g_i[1].wr_n - b1, 1024);
    chk("small_ovf_8K", int'(g_i[1].bus.OVERFLOW), 1);
    chk("small_cfg_8K", int'(g_i[1].bus.CFG_AW), 11);

    // Just past a power of two.
    download(2049, 1, 0);
    wait_loaded("loaded_2049", 6);
    chk("cfg_2049", int'(g_i[0].bus.CFG_AW), 12);

    // Larger than the CPU window.
    download(40960, 1, 0);
    wait_loaded("loaded_40K", 6);
    chk("cfg_40K", int'(g_i[0].bus.CFG_AW), 15);
    chk("ovf_40K", int'(g_i[0].bus.OVERFLOW), 0);

    // Overflow on the 1 KiB instance: 2^10 + 1 bytes.
    b1 = g_i[1].wr_n;
    download(1025, 1, 0);
    wait_loaded("loaded_1025", 6);
    chk("small_writes_1025", g_i[1].wr_n - b1, 1024);
    chk("small_last_1025", g_i[1].wr_last, 'h3FF);
    chk("small_ovf_1025", int'(g_i[1].bus.OVERFLOW), 1);
    chk("small_cfg_1025", int'(g_i[1].bus.CFG_AW), 11);
    chk("ovf_1025", int'(g_i[0].bus.OVERFLOW), 0);

    // Empty download.
    b0 = g_i[0].wr_n;
    download(0, 1, 2);
    repeat (4) tick();
    chk("empty_loaded", int'(g_i[0].bus.LOADED), 0);
    chk("empty_writes", g_i[0].wr_n - b0, 0);

    // Reset in the middle of a download.
    act = 1'b1;
    tick();
    for (int i = 0; i < 100; i++) begin
      wr = 1'b1; data = 8'($urandom);
      tick();
      wr = 1'b0;
    end
    chk("valid_before_rst", int'(g_i[0].bus.INIT_VALID), 1);
    nRST = 1'b0;
    #1;
    chk("rst_mid_valid", int'(g_i[0].bus.INIT_VALID), 0);
    chk("rst_mid_loaded", int'(g_i[0].bus.LOADED), 0);
    chk("rst_mid_addr", int'(g_i[0].bus.INIT_ADDR), 0);
    @(posedge CLK);
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    b0 = g_i[0].wr_n;
    for (int i = 0; i < 10; i++) begin
      wr = 1'b1; data = 8'($urandom);
      tick();
      wr = 1'b0;
      tick();
    end
    chk("post_rst_ignored", g_i[0].wr_n - b0, 0);
    act = 1'b0;
    tick();
    tick();
    b0 = g_i[0].wr_n;
    download(16, 1, 0);
    wait_loaded("loaded_16", 6);
    chk("writes_16", g_i[0].wr_n - b0, 16);
    chk("last_16", g_i[0].wr_last, 15);
    chk("cfg_16", int'(g_i[0].bus.CFG_AW), 11);

    // Random downloads; short low gaps can restart during sizing.
    for (int i = 0; i < 10; i++) begin
      if (i % 5 == 0) begin
        n = int'($urandom_range(2049, 2600));
        download(n, 1, 0);
      end else begin
        n = int'($urandom_range(0, 150));
        download(n, 0, 0);
      end
      lo = int'($urandom_range(1, 5));
      for (int k = 0; k < lo; k++) begin
        wr = 1'($urandom % 2);
        data = 8'($urandom);
        tick();
      end
      wr = 1'b0;
    end
    act = 1'b0;
    repeat (10) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
